// File: rtl/mem_write_buffer.sv
// Posted write buffer between the cache memory port and main memory: writes are acked once
// buffered, matching reads are forwarded, and other reads bypass ahead of pending drains.
module mem_write_buffer #(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned ADDR_W = 15,
   parameter int unsigned DATA_W = 256
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  c_req_valid,
   input  logic                  c_req_rw,
   input  logic [ADDR_W-1:0]     c_req_addr,
   input  logic [DATA_W-1:0]     c_req_wdata,
   output logic                  c_resp_valid,
   output logic [DATA_W-1:0]     c_resp_rdata,
   output logic                  m_req_valid,
   output logic                  m_req_rw,
   output logic [ADDR_W-1:0]     m_req_addr,
   output logic [DATA_W-1:0]     m_req_wdata,
   input  logic                  m_resp_valid,
   input  logic [DATA_W-1:0]     m_resp_rdata,
   output logic [$clog2(DEPTH):0] wb_count,
   output logic                  wb_empty
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {CIdle, CRdWait, CResp} c_state_e;
   typedef enum logic [1:0] {MIdle, MWaitRd, MWaitWr} m_state_e;

   c_state_e c_state_q, c_state_d;
   m_state_e m_state_q, m_state_d;

   logic [DEPTH-1:0]  valid_q;
   logic [ADDR_W-1:0] addr_q [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [PTR_W-1:0]  head_q, tail_q;
   logic [CNT_W-1:0]  count_q, count_d;

   logic              rd_pending_q;
   logic [ADDR_W-1:0] rd_addr_q;
   logic              c_resp_valid_q;
   logic [DATA_W-1:0] c_resp_rdata_q;
   logic              m_req_valid_q, m_req_rw_q;
   logic [ADDR_W-1:0] m_req_addr_q;
   logic [DATA_W-1:0] m_req_wdata_q;
   logic              wb_empty_q;

   logic             wr_hit, rd_hit;
   logic [PTR_W-1:0] wr_idx, rd_idx;
   logic             c_accept, do_coalesce, do_push, do_rd_hit, do_rd_miss, rd_done;
   logic             issue_rd, issue_wr, do_pop, head_busy;

   // Hold off sampling while the response pulse is out so a still-held request is not re-taken.
   assign c_accept    = (c_state_q == CIdle) && c_req_valid && !c_resp_valid_q;
   assign do_coalesce = c_accept && c_req_rw && wr_hit;
   assign do_push     = c_accept && c_req_rw && !wr_hit && (count_q != CNT_W'(DEPTH));
   assign do_rd_hit   = c_accept && !c_req_rw && rd_hit;
   assign do_rd_miss  = c_accept && !c_req_rw && !rd_hit;
   assign rd_done     = (c_state_q == CRdWait) && (m_state_q == MWaitRd) && m_resp_valid;

   assign issue_rd  = (m_state_q == MIdle) && rd_pending_q;
   assign issue_wr  = (m_state_q == MIdle) && !rd_pending_q && (count_q != '0);
   assign do_pop    = (m_state_q == MWaitWr) && m_resp_valid;
   // The head is frozen from the edge its drain is issued until it pops.
   assign head_busy = (m_state_q == MWaitWr) || issue_wr;

   always_comb begin
      wr_hit = 1'b0;
      wr_idx = '0;
      rd_hit = 1'b0;
      rd_idx = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (valid_q[i] && (addr_q[i] == c_req_addr)) begin
            if (!(head_busy && (PTR_W'(i) == head_q))) begin
               wr_hit = 1'b1;
               wr_idx = PTR_W'(i);
            end
            // A non-head match is always newer than an in-flight head copy.
            if (!rd_hit || (PTR_W'(i) != head_q)) begin
               rd_hit = 1'b1;
               rd_idx = PTR_W'(i);
            end
         end
      end
   end

   always_comb begin
      c_state_d = c_state_q;
      unique case (c_state_q)
         CIdle: begin
            if (do_coalesce || do_push || do_rd_hit) c_state_d = CResp;
            else if (do_rd_miss)                     c_state_d = CRdWait;
         end
         CRdWait: if (rd_done) c_state_d = CResp;
         CResp:   c_state_d = CIdle;
         default: c_state_d = CIdle;
      endcase
   end

   always_comb begin
      m_state_d = m_state_q;
      unique case (m_state_q)
         MIdle: begin
            if (issue_rd)      m_state_d = MWaitRd;
            else if (issue_wr) m_state_d = MWaitWr;
         end
         MWaitRd: if (m_resp_valid) m_state_d = MIdle;
         MWaitWr: if (m_resp_valid) m_state_d = MIdle;
         default: m_state_d = MIdle;
      endcase
   end

   assign count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         c_state_q      <= CIdle;
         m_state_q      <= MIdle;
         valid_q        <= '0;
         head_q         <= '0;
         tail_q         <= '0;
         count_q        <= '0;
         rd_pending_q   <= 1'b0;
         rd_addr_q      <= '0;
         c_resp_valid_q <= 1'b0;
         c_resp_rdata_q <= '0;
         m_req_valid_q  <= 1'b0;
         m_req_rw_q     <= 1'b0;
         m_req_addr_q   <= '0;
         m_req_wdata_q  <= '0;
         wb_empty_q     <= 1'b1;
      end else begin
         c_state_q      <= c_state_d;
         m_state_q      <= m_state_d;
         count_q        <= count_d;
         wb_empty_q     <= (count_d == '0);
         c_resp_valid_q <= (c_state_q == CResp);
         m_req_valid_q  <= issue_rd || issue_wr;

         if (do_rd_hit)    c_resp_rdata_q <= data_q[rd_idx];
         else if (rd_done) c_resp_rdata_q <= m_resp_rdata;

         if (do_rd_miss) begin
            rd_pending_q <= 1'b1;
            rd_addr_q    <= c_req_addr;
         end else if (issue_rd) begin
            rd_pending_q <= 1'b0;
         end

         if (issue_rd) begin
            m_req_rw_q   <= 1'b0;
            m_req_addr_q <= rd_addr_q;
         end else if (issue_wr) begin
            m_req_rw_q    <= 1'b1;
            m_req_addr_q  <= addr_q[head_q];
            m_req_wdata_q <= data_q[head_q];
         end

         if (do_push) begin
            valid_q[tail_q] <= 1'b1;
            tail_q          <= tail_q + PTR_W'(1);
         end
         if (do_pop) begin
            valid_q[head_q] <= 1'b0;
            head_q          <= head_q + PTR_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         addr_q[tail_q] <= c_req_addr;
         data_q[tail_q] <= c_req_wdata;
      end else if (do_coalesce) begin
         data_q[wr_idx] <= c_req_wdata;
      end
   end

   assign c_resp_valid = c_resp_valid_q;
   assign c_resp_rdata = c_resp_rdata_q;
   assign m_req_valid  = m_req_valid_q;
   assign m_req_rw     = m_req_rw_q;
   assign m_req_addr   = m_req_addr_q;
   assign m_req_wdata  = m_req_wdata_q;
   assign wb_count     = count_q;
   assign wb_empty     = wb_empty_q;

endmodule

// File: tb/tb_mem_write_buffer.sv
// Bench for mem_write_buffer: a latency-configurable memory responder plus a reference model
// in which every read returns the most recent acknowledged write to that block address.
module tb_mem_write_buffer;

   localparam int unsigned DEPTH  = 4;
   localparam int unsigned ADDR_W = 15;
   localparam int unsigned DATA_W = 256;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic              c_req_valid = 1'b0;
   logic              c_req_rw = 1'b0;
   logic [ADDR_W-1:0] c_req_addr = '0;
   logic [DATA_W-1:0] c_req_wdata = '0;
   logic              c_resp_valid;
   logic [DATA_W-1:0] c_resp_rdata;
   logic              m_req_valid, m_req_rw;
   logic [ADDR_W-1:0] m_req_addr;
   logic [DATA_W-1:0] m_req_wdata;
   logic              m_resp_valid;
   logic [DATA_W-1:0] m_resp_rdata = '0;
   logic [2:0]        wb_count;
   logic              wb_empty;
   logic              resp_pulse = 1'b0;
   logic              inject = 1'b0;

   assign m_resp_valid = resp_pulse | inject;

   mem_write_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk(clk), .rst(rst),
      .c_req_valid(c_req_valid), .c_req_rw(c_req_rw), .c_req_addr(c_req_addr),
      .c_req_wdata(c_req_wdata), .c_resp_valid(c_resp_valid), .c_resp_rdata(c_resp_rdata),
      .m_req_valid(m_req_valid), .m_req_rw(m_req_rw), .m_req_addr(m_req_addr),
      .m_req_wdata(m_req_wdata), .m_resp_valid(m_resp_valid), .m_resp_rdata(m_resp_rdata),
      .wb_count(wb_count), .wb_empty(wb_empty)
   );

   int errors = 0;
   int checks = 0;
   int ncyc = 0;

   logic [DATA_W-1:0] mem [int];
   logic [DATA_W-1:0] model [int];
   bit                log_rw [$];
   int                log_addr [$];
   logic [DATA_W-1:0] log_data [$];
   int                log_req_cyc [$];
   int                log_resp_cyc [0:4095];

   int mem_lat = 5;
   bit lat_rand = 1'b0;
   bit busy = 1'b0;
   int cnt, cur_addr, cur_idx;
   bit cur_rw;
   logic [DATA_W-1:0] cur_data;

   function automatic logic [DATA_W-1:0] init_blk(int a);
      logic [31:0] w;
      w = 32'hA500_0000 | 32'(a);
      return {8{w}};
   endfunction

   function automatic logic [DATA_W-1:0] mem_val(int a);
      return mem.exists(a) ? mem[a] : init_blk(a);
   endfunction

   function automatic logic [DATA_W-1:0] model_val(int a);
      return model.exists(a) ? model[a] : init_blk(a);
   endfunction

   // Single-outstanding memory: requests sampled and responses driven on the falling edge.
   always @(negedge clk) begin
      ncyc++;
      resp_pulse = 1'b0;
      if (rst) begin
         busy = 1'b0;
      end else if (busy) begin
         if (cnt == 0) begin
            resp_pulse = 1'b1;
            busy = 1'b0;
            log_resp_cyc[cur_idx] = ncyc;
            if (cur_rw) mem[cur_addr] = cur_data;
            else        m_resp_rdata = mem_val(cur_addr);
         end else begin
            cnt--;
         end
      end else if (m_req_valid) begin
         busy = 1'b1;
         cur_rw = m_req_rw;
         cur_addr = int'(m_req_addr);
         cur_data = m_req_wdata;
         cur_idx = log_rw.size();
         log_rw.push_back(cur_rw);
         log_addr.push_back(cur_addr);
         log_data.push_back(cur_data);
         log_req_cyc.push_back(ncyc);
         cnt = (lat_rand ? int'($urandom_range(1, 6)) : mem_lat) - 1;
      end
   end

   task automatic check(input string tag, input logic [DATA_W-1:0] got,
                        input logic [DATA_W-1:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_int(input string tag, input int got, input int exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   // One cache request; lat counts cycles from raising valid to seeing the response.
   task automatic cache_op(input bit rw, input int addr, input logic [DATA_W-1:0] wd,
                           output int lat);
      tick();
      c_req_valid = 1'b1;
      c_req_rw = rw;
      c_req_addr = ADDR_W'(addr);
      c_req_wdata = wd;
      lat = 0;
      do begin
         tick();
         lat++;
      end while (!c_resp_valid && lat < 1000);
      check_int("resp_seen", int'(c_resp_valid), 1);
      c_req_valid = 1'b0;
      if (rw && c_resp_valid) model[addr] = wd;
   endtask

   task automatic wait_idle();
      int k;
      bit idle;
      k = 0;
      idle = wb_empty && !busy && !m_req_valid && !resp_pulse;
      while (!idle && k < 3000) begin
         tick();
         k++;
         idle = wb_empty && !busy && !m_req_valid && !resp_pulse;
      end
      check_int("idle_reached", int'(idle), 1);
   endtask

   function automatic logic [DATA_W-1:0] rand_blk();
      logic [DATA_W-1:0] d;
      for (int k = 0; k < 8; k++) d[k*32 +: 32] = $urandom();
      return d;
   endfunction

   function automatic int count_reads();
      int n;
      n = 0;
      foreach (log_rw[i]) if (!log_rw[i]) n++;
      return n;
   endfunction

   initial begin
      int lat, base, n, saw, a;
      logic [DATA_W-1:0] d, blk_b, blk_c;
      int exp_addr [4];
      bit exp_rw [4];

      repeat (3) tick();
      check_int("rst_c_resp_valid", int'(c_resp_valid), 0);
      check_int("rst_m_req_valid", int'(m_req_valid), 0);
      check_int("rst_wb_count", int'(wb_count), 0);
      check_int("rst_wb_empty", int'(wb_empty), 1);
      rst = 1'b0;

      // Basic posted write then drain.
      mem_lat = 5;
      d = {8{32'h1111_1111}};
      cache_op(1'b1, 'h10, d, lat);
      check_int("t1_latency", lat, 2);
      check_int("t1_count", int'(wb_count), 1);
      check_int("t1_mreq_valid", int'(m_req_valid), 1);
      check_int("t1_mreq_rw", int'(m_req_rw), 1);
      check_int("t1_mreq_addr", int'(m_req_addr), 'h10);
      check("t1_mreq_wdata", m_req_wdata, d);
      wait_idle();
      check_int("t1_count_drained", int'(wb_count), 0);
      check_int("t1_empty", int'(wb_empty), 1);
      check("t1_mem", mem_val('h10), d);

      // Read forwarded from the in-flight head, no memory read.
      mem_lat = 20;
      d = rand_blk();
      cache_op(1'b1, 'h20, d, lat);
      n = count_reads();
      cache_op(1'b0, 'h20, '0, lat);
      check_int("t2_latency", lat, 2);
      check("t2_fwd_data", c_resp_rdata, d);
      check_int("t2_no_mem_read", count_reads(), n);
      wait_idle();

      // Coalescing behind an in-flight head.
      base = log_rw.size();
      blk_b = rand_blk();
      blk_c = rand_blk();
      cache_op(1'b1, 'h10, rand_blk(), lat);
      cache_op(1'b1, 'h30, blk_b, lat);
      cache_op(1'b1, 'h30, blk_c, lat);
      check_int("t3_count", int'(wb_count), 2);
      wait_idle();
      saw = 0;
      d = '0;
      for (int i = base; i < log_rw.size(); i++) begin
         if (log_addr[i] == 'h30) begin
            saw++;
            d = log_data[i];
         end
      end
      check_int("t3_single_drain", saw, 1);
      check("t3_drain_data", d, blk_c);

      // Full buffer stalls the fifth write until the first pop.
      mem_lat = 50;
      base = log_rw.size();
      for (int k = 0; k < 4; k++) cache_op(1'b1, 'h41 + k, rand_blk(), lat);
      check_int("t4_full_count", int'(wb_count), 4);
      cache_op(1'b1, 'h45, rand_blk(), lat);
      check_int("t4_resp_after_pop", ncyc, log_resp_cyc[base] + 3);
      check_int("t4_count_back", int'(wb_count), 4);
      check_int("t4_one_pop", log_rw.size() - base, 2);
      wait_idle();

      // Read miss bypasses remaining drains.
      mem_lat = 20;
      base = log_rw.size();
      for (int k = 0; k < 3; k++) cache_op(1'b1, 'h50 + k, rand_blk(), lat);
      cache_op(1'b0, 'h100, '0, lat);
      check("t5_miss_data", c_resp_rdata, model_val('h100));
      wait_idle();
      exp_addr = '{'h50, 'h100, 'h51, 'h52};
      exp_rw = '{1'b1, 1'b0, 1'b1, 1'b1};
      for (int k = 0; k < 4; k++) begin
         check_int("t5_order_addr", log_addr[base + k], exp_addr[k]);
         check_int("t5_order_rw", int'(log_rw[base + k]), int'(exp_rw[k]));
      end
      check_int("t5_rd_issue_cycle", log_req_cyc[base + 1], log_resp_cyc[base] + 2);

      // Reset with two entries buffered and a drain in flight.
      mem_lat = 30;
      base = log_rw.size();
      cache_op(1'b1, 'h200, rand_blk(), lat);
      cache_op(1'b1, 'h201, rand_blk(), lat);
      check_int("t6_count", int'(wb_count), 2);
      rst = 1'b1;
      #1;
      check_int("t6_c_resp_valid", int'(c_resp_valid), 0);
      check("t6_c_resp_rdata", c_resp_rdata, '0);
      check_int("t6_m_req_valid", int'(m_req_valid), 0);
      check_int("t6_m_req_rw", int'(m_req_rw), 0);
      check_int("t6_m_req_addr", int'(m_req_addr), 0);
      check("t6_m_req_wdata", m_req_wdata, '0);
      check_int("t6_wb_count", int'(wb_count), 0);
      check_int("t6_wb_empty", int'(wb_empty), 1);
      tick();
      rst = 1'b0;
      inject = 1'b1;
      tick();
      inject = 1'b0;
      saw = 0;
      repeat (6) begin
         tick();
         if (m_req_valid) saw++;
      end
      check_int("t6_late_resp_ignored", saw, 0);
      check_int("t6_count_after", int'(wb_count), 0);
      check_int("t6_log_len", log_rw.size() - base, 1);
      model = mem;
      cache_op(1'b0, 'h200, '0, lat);
      check("t6_discarded", c_resp_rdata, model_val('h200));
      wait_idle();

      // Random mix over a small address pool with random memory latency.
      lat_rand = 1'b1;
      for (int k = 0; k < 80; k++) begin
         a = 'h400 + int'($urandom_range(0, 7));
         if ($urandom_range(0, 1) == 1) begin
            cache_op(1'b1, a, rand_blk(), lat);
         end else begin
            cache_op(1'b0, a, '0, lat);
            check("rnd_read", c_resp_rdata, model_val(a));
         end
      end
      wait_idle();
      for (int k = 0; k < 8; k++) check("rnd_final_mem", mem_val('h400 + k), model_val('h400 + k));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
